camera_capture_ctrl: RTL

- Parametrised camera-to-frame-buffer writer. Successor to the fixed 480x272 RGB565 capture path.
- Sits between the camera pins and the frame-buffer BRAM write port.
- Adds configurable geometry, 1- or 2-byte pixels, and ping-pong double buffering.
- Adds an FSM with single-shot/continuous modes, whole-frame alignment, and frame-done/error status.

---
 rtl/camera_capture_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/camera_capture_ctrl.sv
// Camera-to-frame-buffer writer: stages the camera pins, assembles 8/16-bit pixels,
// windows them to H_ACTIVE x V_ACTIVE and writes them into one of two ping-pong banks.
module camera_capture_ctrl #(
    parameter int H_ACTIVE      = 480,
    parameter int V_ACTIVE      = 272,
    parameter int BYTES_PER_PIX = 2,
    parameter int DOUBLE_BUF    = 1,
    parameter int ADDR_W        = 18
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              continuous_i,
    input  logic              cam_vsync_i,
    input  logic              cam_hsync_i,
    input  logic [7:0]        cam_data_i,
    output logic              ram_wr_en_o,
    output logic [ADDR_W-1:0] ram_wr_addr_o,
    output logic [15:0]       ram_wr_data_o,
    output logic              frame_done_o,
    output logic              rd_bank_o,
    output logic              busy_o,
    output logic              frame_err_o
);

    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int HC_W  = $clog2(H_ACTIVE + 1);
    localparam int VC_W  = $clog2(V_ACTIVE + 1);
    localparam logic [ADDR_W-1:0] TOTAL_A = ADDR_W'(TOTAL);
    localparam logic [HC_W-1:0]   H_LIM   = HC_W'(H_ACTIVE);
    localparam logic [VC_W-1:0]   V_LIM   = VC_W'(V_ACTIVE);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARM      = 3'd1;
    localparam logic [2:0] S_WAIT_SOF = 3'd2;
    localparam logic [2:0] S_CAPTURE  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic              r_vs_p1, r_vs_p2, r_vs_p3;
    logic              r_hs_p1, r_hs_p2, r_hs_p3;
    logic [7:0]        r_data_p1, r_data_p2;
    logic [7:0]        r_msb;
    logic              r_phase;
    logic              r_en_d;
    logic [2:0]        r_state;
    logic [HC_W-1:0]   r_h_cnt;
    logic [VC_W-1:0]   r_v_cnt;
    logic [ADDR_W-1:0] r_pix_cnt;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [15:0]       r_wr_data;
    logic              r_done;
    logic              r_err;

    logic              w_byte, w_pix_done, w_in_window, w_write;
    logic              w_vs_fall, w_vs_rise, w_hs_fall, w_start, w_frame_ok;
    logic [15:0]       w_pix_data;
    logic [ADDR_W-1:0] w_base;

    // Stage 1/2: synchroniser for the camera pins; p3 holds the previous stage-2 sample
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vs_p1 <= 1'b0;
            r_vs_p2 <= 1'b0;
            r_vs_p3 <= 1'b0;
            r_hs_p1 <= 1'b0;
            r_hs_p2 <= 1'b0;
            r_hs_p3 <= 1'b0;
        end else begin
            r_vs_p1 <= cam_vsync_i;
            r_vs_p2 <= r_vs_p1;
            r_vs_p3 <= r_vs_p2;
            r_hs_p1 <= cam_hsync_i;
            r_hs_p2 <= r_hs_p1;
            r_hs_p3 <= r_hs_p2;
        end
    end

    always_ff @(posedge clk_i) begin
        r_data_p1 <= cam_data_i;
        r_data_p2 <= r_data_p1;
        if (w_byte && !r_phase)
            r_msb <= r_data_p2;
    end

    // Tracks enable_i through reset too, so a level held across reset is not seen as an edge
    always_ff @(posedge clk_i) begin
        r_en_d <= enable_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_phase <= 1'b0;
        else if (w_byte)
            r_phase <= ~r_phase;
        else
            r_phase <= 1'b0;
    end

    assign w_byte      = r_hs_p2 && !r_vs_p2;
    assign w_pix_done  = w_byte && ((BYTES_PER_PIX == 1) || r_phase);
    assign w_pix_data  = (BYTES_PER_PIX == 1) ? {8'h00, r_data_p2} : {r_msb, r_data_p2};
    assign w_in_window = (r_h_cnt < H_LIM) && (r_v_cnt < V_LIM) && (r_pix_cnt < TOTAL_A);
    assign w_write     = (r_state == S_CAPTURE) && w_pix_done && w_in_window;
    assign w_vs_fall   = r_vs_p3 && !r_vs_p2;
    assign w_vs_rise   = !r_vs_p3 && r_vs_p2;
    assign w_hs_fall   = r_hs_p3 && !r_hs_p2;
    assign w_start     = continuous_i ? enable_i : (enable_i && !r_en_d);
    assign w_frame_ok  = (r_pix_cnt == TOTAL_A);
    assign w_base      = ((DOUBLE_BUF != 0) && r_wr_bank) ? TOTAL_A : '0;

    // Stage 3: write port registers and capture FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_pix_cnt <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= w_write;
            r_done  <= 1'b0;
            if (w_write) begin
                r_wr_addr <= w_base + r_pix_cnt;
                r_wr_data <= w_pix_data;
                r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start)
                        r_state <= S_ARM;
                end
                S_ARM: begin
                    // Waiting for blanking guarantees a frame already underway is skipped
                    if (r_vs_p2)
                        r_state <= S_WAIT_SOF;
                end
                S_WAIT_SOF: begin
                    if (w_vs_fall) begin
                        r_state   <= S_CAPTURE;
                        r_h_cnt   <= '0;
                        r_v_cnt   <= '0;
                        r_pix_cnt <= '0;
                        r_err     <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (w_vs_rise) begin
                        r_state <= S_DONE;
                    end else begin
                        if (!r_hs_p2)
                            r_h_cnt <= '0;
                        else if (w_pix_done && (r_h_cnt < H_LIM))
                            r_h_cnt <= r_h_cnt + HC_W'(1);
                        if (w_hs_fall && (r_v_cnt < V_LIM))
                            r_v_cnt <= r_v_cnt + VC_W'(1);
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    if (w_frame_ok) begin
                        r_rd_bank <= r_wr_bank;
                        if (DOUBLE_BUF != 0)
                            r_wr_bank <= ~r_wr_bank;
                    end else begin
                        r_err <= 1'b1;
                    end
                    r_state <= (continuous_i && enable_i) ? S_WAIT_SOF : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ram_wr_en_o   = r_wr_en;
    assign ram_wr_addr_o = r_wr_addr;
    assign ram_wr_data_o = r_wr_data;
    assign frame_done_o  = r_done;
    assign rd_bank_o     = r_rd_bank;
    assign busy_o        = (r_state == S_WAIT_SOF) || (r_state == S_CAPTURE);
    assign frame_err_o   = r_err;

endmodule
